// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
// Holds size encodings, FSM states, the latched request and default base.
package dmem_pkg;

   localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h1001_0000;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD,
      ST_WAIT,
      ST_WR,
      ST_DONE
   } state_t;

   typedef struct packed {
      logic        we;
      logic [1:0]  size;
      logic [1:0]  lane;
      logic [31:0] wdata;
   } req_t;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational merge of a right-justified byte/half into a RAM word.
// Ports: old_word, wdata, size, lane in; merged out (word size passes wdata).
module store_lane_merge
   import dmem_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] wdata,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      case (size)
         SZ_HALF: begin
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         SZ_BYTE: begin
            case (lane)
               2'd0:    merged[7:0]   = wdata[7:0];
               2'd1:    merged[15:8]  = wdata[7:0];
               2'd2:    merged[23:16] = wdata[7:0];
               default: merged[31:24] = wdata[7:0];
            endcase
         end
         default: merged = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences loads, word stores and read-modify-write sb/sh on a word RAM.
// Ports: req_* handshake in, mem_* registered RAM strobes out, rsp_* pulse out.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE = DMEM_BASE_DEFAULT,
   parameter int          MEM_AW    = 11
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [31:0]       rsp_rdata
);

   localparam logic [32:0] SPAN = 33'd4 << MEM_AW;

   state_t      state;
   req_t        lat;
   logic [31:0] off;
   logic        err;
   logic [31:0] merged;

   assign off = req_addr - DMEM_BASE;

   // Range uses the raw address so a wrapped offset below base is caught.
   always_comb begin
      err = 1'b0;
      if (req_addr < DMEM_BASE)            err = 1'b1;
      if ({1'b0, off} >= SPAN)             err = 1'b1;
      if (req_size == SZ_ILL)              err = 1'b1;
      if (req_size == SZ_WORD && off[1:0] != 2'd0) err = 1'b1;
      if (req_size == SZ_HALF && off[0])   err = 1'b1;
   end

   store_lane_merge u_merge (
      .old_word (mem_rdata),
      .wdata    (lat.wdata),
      .size     (lat.size),
      .lane     (lat.lane),
      .merged   (merged)
   );

   // mem_* are set on the edge entering RD/WR so they are pure registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         lat       <= '0;
         req_ready <= 1'b1;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  lat <= '{we: req_we, size: req_size,
                           lane: off[1:0], wdata: req_wdata};
                  req_ready <= 1'b0;
                  if (err) begin
                     state     <= ST_DONE;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                  end else if (req_we && req_size == SZ_WORD) begin
                     state     <= ST_WR;
                     mem_en    <= 1'b1;
                     mem_we    <= 1'b1;
                     mem_addr  <= off[MEM_AW+1:2];
                     mem_wdata <= req_wdata;
                  end else begin
                     state    <= ST_RD;
                     mem_en   <= 1'b1;
                     mem_we   <= 1'b0;
                     mem_addr <= off[MEM_AW+1:2];
                  end
               end
            end
            ST_RD: begin
               state  <= ST_WAIT;
               mem_en <= 1'b0;
            end
            ST_WAIT: begin
               if (lat.we) begin
                  state     <= ST_WR;
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_wdata <= merged;
               end else begin
                  state     <= ST_DONE;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= mem_rdata;
               end
            end
            ST_WR: begin
               state     <= ST_DONE;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               rsp_valid <= 1'b1;
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               mem_en    <= 1'b0;
               mem_we    <= 1'b0;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
